// File: rtl/rot3_rotator_if.sv
// Bus interface for rot3_rotator: command/load inputs and register/status outputs.
//   master : drives load/a_in/b_in/c_in/start/dir/steps/abort, observes a/b/c/busy/done/rot_count/err
//   slave  : the rotator side of the same bundle
interface rot3_rotator_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4,
  parameter int unsigned CNT_W  = 8
);
  logic              load;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;
  logic [WIDTH-1:0]  c_in;
  logic              start;
  logic              dir;
  logic [STEP_W-1:0] steps;
  logic              abort;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [WIDTH-1:0]  c;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  rot_count;
  logic              err;

  modport master (
    output load, a_in, b_in, c_in, start, dir, steps, abort,
    input  a, b, c, busy, done, rot_count, err
  );

  modport slave (
    input  load, a_in, b_in, c_in, start, dir, steps, abort,
    output a, b, c, busy, done, rot_count, err
  );
endinterface

// File: rtl/rot3_rotator.sv
// rot3_rotator: three-register circular rotator (a, b, c) with a start/done
// handshake that runs a programmable number of atomic rotation steps.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : rot3_rotator_if.slave
//         in  load, a_in, b_in, c_in, start, dir, steps, abort
//         out a, b, c, busy, done (1-cycle pulse), rot_count, err
// Build option: define ROT3_CHECK_EN to add the sum/XOR permutation checker
// driving a sticky err; otherwise err is tied low.
module rot3_rotator #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  rot3_rotator_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROTATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        r_state, w_state;
  logic [WIDTH-1:0]  r_a, w_a;
  logic [WIDTH-1:0]  r_b, w_b;
  logic [WIDTH-1:0]  r_c, w_c;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [STEP_W-1:0] r_rem, w_rem;
  logic              r_dir, w_dir;
  logic              w_rot;   // this edge performs a rotation step

  // State and datapath registers; every permutation lands on one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_a     <= w_a;
      r_b     <= w_b;
      r_c     <= w_c;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_cnt   <= w_cnt;
      r_rem   <= w_rem;
      r_dir   <= w_dir;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    w_state = r_state;
    w_a     = r_a;
    w_b     = r_b;
    w_c     = r_c;
    w_busy  = r_busy;
    w_done  = r_done;
    w_cnt   = r_cnt;
    w_rem   = r_rem;
    w_dir   = r_dir;
    w_rot   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // load has priority over start
        if (bus.load) begin
          w_a = bus.a_in;
          w_b = bus.b_in;
          w_c = bus.c_in;
        end else if (bus.start) begin
          w_dir = bus.dir;
          w_rem = bus.steps;
          if (bus.steps == '0) begin
            w_done  = 1'b1;
            w_state = S_DONE;
          end else begin
            w_busy  = 1'b1;
            w_state = S_ROTATE;
          end
        end
      end

      S_ROTATE: begin
        // abort is honoured only when this edge is not the final step
        if (bus.abort && (r_rem != STEP_W'(1))) begin
          w_busy  = 1'b0;
          w_done  = 1'b0;
          w_state = S_IDLE;
        end else begin
          w_rot = 1'b1;
          if (r_dir) begin
            w_a = r_c;
            w_b = r_a;
            w_c = r_b;
          end else begin
            w_a = r_b;
            w_b = r_c;
            w_c = r_a;
          end
          w_rem = r_rem - STEP_W'(1);
          w_cnt = r_cnt + CNT_W'(1);
          if (r_rem == STEP_W'(1)) begin
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_done  = 1'b0;
        w_state = S_IDLE;
      end

      default: begin
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_state = S_IDLE;
      end
    endcase
  end

  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.c         = r_c;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rot_count = r_cnt;

`ifdef ROT3_CHECK_EN
  localparam int unsigned SUM_W = WIDTH + 2;

  logic [SUM_W-1:0] w_sum_pre;
  logic [SUM_W-1:0] w_sum_post;
  logic [WIDTH-1:0] w_xor_pre;
  logic [WIDTH-1:0] w_xor_post;
  logic             w_chk_bad;
  logic             r_err;

  // A permutation preserves both the sum and the XOR of the three values
  always_comb begin
    w_sum_pre  = SUM_W'(r_a) + SUM_W'(r_b) + SUM_W'(r_c);
    w_sum_post = SUM_W'(w_a) + SUM_W'(w_b) + SUM_W'(w_c);
    w_xor_pre  = r_a ^ r_b ^ r_c;
    w_xor_post = w_a ^ w_b ^ w_c;
    w_chk_bad  = w_rot && ((w_sum_pre != w_sum_post) || (w_xor_pre != w_xor_post));
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_chk_bad) begin
      r_err <= 1'b1;
`ifndef SYNTHESIS
      $display("%0t rot3_rotator: permutation check failed pre=(%0d,%0d,%0d) post=(%0d,%0d,%0d)",
               $time, r_a, r_b, r_c, w_a, w_b, w_c);
`endif
    end
  end

  assign bus.err = r_err;
`else
  // w_rot only feeds the checker; keep it referenced in the default build
  logic w_rot_unused;
  assign w_rot_unused = w_rot;
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_rot3_rotator.sv
// Directed self-checking bench for rot3_rotator.
module tb_rot3_rotator;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned CNT_W  = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rot3_rotator_if #(.WIDTH(WIDTH), .STEP_W(STEP_W), .CNT_W(CNT_W)) bus ();

  rot3_rotator #(.WIDTH(WIDTH), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc);
    bus.load = 1'b1;
    bus.a_in = va;
    bus.b_in = vb;
    bus.c_in = vc;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic check_abc(input string tag, input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec);
    check({tag, ".a"}, 32'(bus.a), 32'(ea));
    check({tag, ".b"}, 32'(bus.b), 32'(eb));
    check({tag, ".c"}, 32'(bus.c), 32'(ec));
  endtask

  // start a command and wait (bounded) for done; edges counts the start edge as 1
  task automatic run_cmd(input logic d, input logic [3:0] s, output int edges, output int busy_cyc);
    bus.start = 1'b1;
    bus.dir   = d;
    bus.steps = s;
    tick();
    bus.start = 1'b0;
    bus.dir   = ~d;      // must be ignored while busy
    bus.steps = 4'd2;
    edges     = 1;
    busy_cyc  = 0;
    while (!bus.done && edges < 64) begin
      if (bus.busy) busy_cyc++;
      tick();
      edges++;
    end
    if (!bus.done) check("done_timeout", 32'(bus.done), 32'd1);
  endtask

  int edges;
  int busy_cyc;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.c_in  = '0;
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.steps = '0;
    bus.abort = 1'b0;
    tick();
    tick();
    check_abc("rst", 8'd0, 8'd0, 8'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.cnt", 32'(bus.rot_count), 32'd0);
    rst = 1'b0;
    tick();

    // forward single step
    do_load(8'd6, 8'd1, 8'd7);
    check_abc("load", 8'd6, 8'd1, 8'd7);
    run_cmd(1'b0, 4'd1, edges, busy_cyc);
    check_abc("fwd1", 8'd1, 8'd7, 8'd6);
    check("fwd1.lat", 32'(edges), 32'd2);
    check("fwd1.cnt", 32'(bus.rot_count), 32'd1);
    check("fwd1.busy", 32'(bus.busy), 32'd0);
    tick();
    check("fwd1.done_clr", 32'(bus.done), 32'd0);

    // reverse single step
    do_load(8'd6, 8'd1, 8'd7);
    run_cmd(1'b1, 4'd1, edges, busy_cyc);
    check_abc("rev1", 8'd7, 8'd6, 8'd1);
    check("rev1.cnt", 32'(bus.rot_count), 32'd2);
    tick();

    // three forward steps are the identity
    do_load(8'd6, 8'd1, 8'd7);
    run_cmd(1'b0, 4'd3, edges, busy_cyc);
    check_abc("id3", 8'd6, 8'd1, 8'd7);
    check("id3.lat", 32'(edges), 32'd4);
    check("id3.busy_cyc", 32'(busy_cyc), 32'd3);
    check("id3.cnt", 32'(bus.rot_count), 32'd5);
    tick();
    check("id3.done_clr", 32'(bus.done), 32'd0);

    // zero steps: done after one edge, nothing rotates; start in DONE ignored
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    bus.steps = 4'd0;
    tick();
    check("zero.done", 32'(bus.done), 32'd1);
    check("zero.busy", 32'(bus.busy), 32'd0);
    bus.steps = 4'd1;    // start still high during DONE
    tick();
    bus.start = 1'b0;
    check("zero.done_clr", 32'(bus.done), 32'd0);
    check("zero.busy_in_done", 32'(bus.busy), 32'd0);
    tick();
    check_abc("zero", 8'd6, 8'd1, 8'd7);
    check("zero.cnt", 32'(bus.rot_count), 32'd5);

    // load and start together: load wins
    bus.load  = 1'b1;
    bus.start = 1'b1;
    bus.steps = 4'd2;
    bus.a_in  = 8'd9;
    bus.b_in  = 8'd8;
    bus.c_in  = 8'd3;
    tick();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    check_abc("ldst", 8'd9, 8'd8, 8'd3);
    check("ldst.busy", 32'(bus.busy), 32'd0);
    check("ldst.done", 32'(bus.done), 32'd0);
    tick();
    check("ldst.done2", 32'(bus.done), 32'd0);
    check("ldst.cnt", 32'(bus.rot_count), 32'd5);

    // abort after two rotations
    do_load(8'd6, 8'd1, 8'd7);
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    bus.steps = 4'd5;
    tick();
    bus.start = 1'b0;
    check("abort.busy0", 32'(bus.busy), 32'd1);
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_abc("abort", 8'd7, 8'd6, 8'd1);
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    check("abort.cnt", 32'(bus.rot_count), 32'd7);
    tick();
    tick();
    check("abort.no_done", 32'(bus.done), 32'd0);
    check_abc("abort.hold", 8'd7, 8'd6, 8'd1);

    // abort coinciding with the final step is ignored
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    bus.steps = 4'd1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_last.done", 32'(bus.done), 32'd1);
    check_abc("abort_last", 8'd6, 8'd1, 8'd7);
    check("abort_last.cnt", 32'(bus.rot_count), 32'd8);
    tick();

    // counter wrap: 8 + 16*15 + 7 = 255, then one more -> 0
    for (int i = 0; i < 16; i++) begin
      run_cmd(1'b0, 4'd15, edges, busy_cyc);
      tick();
    end
    check("wrap.cnt248", 32'(bus.rot_count), 32'd248);
    run_cmd(1'b0, 4'd7, edges, busy_cyc);
    check("wrap.cnt255", 32'(bus.rot_count), 32'd255);
    check_abc("wrap255", 8'd1, 8'd7, 8'd6);
    tick();
    run_cmd(1'b0, 4'd1, edges, busy_cyc);
    check("wrap.cnt0", 32'(bus.rot_count), 32'd0);
    check_abc("wrap0", 8'd7, 8'd6, 8'd1);
    check("err", 32'(bus.err), 32'd0);
    tick();

    // asynchronous reset while busy
    bus.start = 1'b1;
    bus.dir   = 1'b1;
    bus.steps = 4'd9;
    tick();
    bus.start = 1'b0;
    tick();
    check("arst.busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_abc("arst", 8'd0, 8'd0, 8'd0);
    check("arst.busy", 32'(bus.busy), 32'd0);
    check("arst.done", 32'(bus.done), 32'd0);
    check("arst.cnt", 32'(bus.rot_count), 32'd0);
    check("arst.err", 32'(bus.err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("arst.idle_busy", 32'(bus.busy), 32'd0);
    check("arst.idle_cnt", 32'(bus.rot_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rot3_rotator.md
Name: rot3_rotator

Overview:
- Three-register circular rotator for registers a, b and c, with all rotation updates in a single clock edge using non-blocking semantics.
- Each step is an atomic permutation of the three registers, so no intermediate value leaks between registers within a step.
- A start/done handshake runs a programmable number of rotation steps in either direction.
- Used as the known-good datapath in the procedural-assignment exercise set and as a reusable rotate unit.

Parameters:
WIDTH, 8, width of each data register a/b/c.
STEP_W, 4, width of the steps request field (max 15 steps per command).
CNT_W, 8, width of the lifetime rotation counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset; asynchronous, active-high.
load  input  1  load a_in/b_in/c_in into a/b/c (IDLE only).
a_in  input  WIDTH  load value for a.
b_in  input  WIDTH  load value for b.
c_in  input  WIDTH  load value for c.
start  input  1  begin a rotation command (IDLE only).
dir  input  1  0 = forward (a<-b, b<-c, c<-a); 1 = reverse (a<-c, b<-a, c<-b).
steps  input  STEP_W  number of rotation steps for the command.
abort  input  1  cancel an in-progress command.
a  output  WIDTH  register a.
b  output  WIDTH  register b.
c  output  WIDTH  register c.
busy  output  1  command in progress.
done  output  1  one-cycle completion pulse.
rot_count  output  CNT_W  total rotation steps performed since reset.
err  output  1  sticky invariant-check failure (see Optional Feature).

Behaviour:
- Reset: asynchronous and active-high. Asserting rst immediately forces:
  - a, b, c, busy, done, rot_count and err to 0;
  - the FSM to IDLE.
  - This applies mid-command as well; any partial rotation is discarded.
- FSM states: IDLE, ROTATE, DONE.
- IDLE:
  - load=1: a/b/c take a_in/b_in/c_in on the next edge.
  - load=1 and start=1 together: load wins and start is ignored.
  - start=1 with load=0: latch dir and steps.
    - steps=0: go to DONE with no rotation.
    - steps>0: busy<=1, remaining<=steps, go to ROTATE. No rotation occurs on the start edge.
- ROTATE:
  - Each edge performs exactly one permutation per the latched dir.
  - Each step decrements remaining and increments rot_count.
  - On the edge performing the final step: busy<=0, done<=1, go to DONE.
  - Latency: start edge to done high = steps+1 edges.
  - dir and steps inputs are ignored while busy.
  - load and start are ignored while busy.
- DONE: done held high for exactly one cycle, then done<=0 and return to IDLE. A start in this cycle is ignored.
- abort (ROTATE only): on the next edge, return to IDLE with busy<=0 and done<=0.
  - a/b/c retain the partially rotated values.
  - An abort on the same edge as the final step is ignored; done pulses normally.
  - abort in IDLE or DONE has no effect.
- Permutation:
  - All three registers update simultaneously from pre-edge values.
  - Forward and reverse are inverses of each other.
  - Three steps in the same direction are the identity.
- rot_count wraps modulo 2^CNT_W (255 -> 0 at default) with no saturation.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ROT3_CHECK_EN.
- When defined:
  - On every rotation edge, compare the pre-edge multiset {a,b,c} against the post-rotation values using a WIDTH+2-bit sum and XOR-reduction.
  - Any mismatch sets err<=1, which holds until rst.
  - In simulation, also issue a $display with $time and the values.
- When undefined: err is tied to 0, no checker logic is generated, and all other behaviour is identical.

Test Plan:
- Reset then idle: rst pulsed high mid-sim while busy -> a=b=c=0, busy=0, done=0, rot_count=0 immediately, without waiting for a clock edge.
- Forward single step: load 6,1,7; start dir=0 steps=1.
  - Required: a=1, b=7, c=6, with done high exactly 2 edges after start and rot_count=1.
  - A blocking-assignment implementation produces c=1 and must fail this check.
- Reverse single step: load 6,1,7; start dir=1 steps=1 -> a=7, b=6, c=1.
- Identity and latency: load 6,1,7; start dir=0 steps=3 -> a=6, b=1, c=7, busy high for 3 cycles, done pulse at edge 4, rot_count=3.
- Zero steps and priority:
  - steps=0 -> done pulses one cycle later with a/b/c unchanged.
  - load and start asserted together -> load applied, no rotation, done stays 0.
- Abort and wrap:
  - start steps=5, abort after 2 rotations -> a=7, b=6, c=1 (from 6,1,7), busy=0, no done pulse.
  - Run 256 total steps -> rot_count returns to 0.
  - With ROT3_CHECK_EN defined, err stays 0 throughout.
